// File: rtl/dm_store.sv
// dm_store: 4096-word data memory for the MEM stage with byte-enable stores,
// asynchronous whole-word read, misalignment flags and a store log.
// Optional feature macro: DM_MISALIGN_TRAP_EN (misaligned stores trap instead of committing).
module dm_store #(
    parameter int unsigned WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic        re,
    input  logic [2:0]  op,
    input  logic [31:0] Addr,
    input  logic [31:0] Din,
    input  logic [31:0] PC,
    output logic [31:0] Dout,
    output logic [3:0]  be,
    output logic        AdEL,
    output logic        AdES
);

    localparam int unsigned AW = $clog2(WORDS);

    logic [31:0]   r_mem [WORDS];

    logic [AW-1:0] w_idx;
    logic [31:0]   w_old;
    logic [31:0]   w_lane;
    logic [31:0]   w_merged;
    logic [3:0]    w_mask;
    logic          w_is_word;
    logic          w_is_half;
    logic          w_mis;
    logic          w_suppress;
    logic          w_commit;
    logic          w_unused;

    assign w_idx = Addr[AW+1:2];
    assign w_old = r_mem[w_idx];
    assign Dout  = w_old;

    assign w_is_word = (op == 3'b000);
    assign w_is_half = (op == 3'b011) || (op == 3'b100);

    always_comb begin
        w_mask = '0;
        case (op)
            3'b000:         w_mask = 4'b1111;
            3'b001, 3'b010: w_mask = 4'b0001 << Addr[1:0];
            3'b011, 3'b100: w_mask = Addr[1] ? 4'b1100 : 4'b0011;
            default:        w_mask = '0;
        endcase
    end

    always_comb begin
        w_lane = {4{Din[7:0]}};
        case (op)
            3'b000:         w_lane = Din;
            3'b011, 3'b100: w_lane = {2{Din[15:0]}};
            default:        w_lane = {4{Din[7:0]}};
        endcase
    end

    always_comb begin
        w_merged = w_old;
        for (int unsigned i = 0; i < 4; i++) begin
            if (w_mask[i]) begin
                w_merged[8*i +: 8] = w_lane[8*i +: 8];
            end
        end
    end

    // be is only meaningful while an access is in flight.
    assign be    = (we || re) ? w_mask : '0;
    assign w_mis = (w_is_word && (Addr[1:0] != 2'b00)) || (w_is_half && Addr[0]);

`ifdef DM_MISALIGN_TRAP_EN
    assign AdES       = we && w_mis;
    assign AdEL       = re && w_mis;
    assign w_suppress = AdES;
`else
    assign AdES       = 1'b0;
    assign AdEL       = 1'b0;
    assign w_suppress = 1'b0;
`endif

    // Illegal op yields an empty mask, so it never commits.
    assign w_commit = we && (w_mask != 4'b0000) && !w_suppress;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            r_mem[w_idx] <= w_merged;
`ifndef SYNTHESIS
            $display("@%h: *%h <= %h", PC, {Addr[31:2], 2'b00}, w_merged);
`endif
        end
    end

    assign w_unused = &{1'b0, Addr[31:AW+2], PC, w_mis};

endmodule

// File: tb/tb_dm_store.sv
// Scoreboard bench for dm_store: directed scenarios plus a randomized burst
// checked against a byte-lane memory model.
module tb_dm_store;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic        re;
    logic [2:0]  op;
    logic [31:0] Addr;
    logic [31:0] Din;
    logic [31:0] PC;
    logic [31:0] Dout;
    logic [3:0]  be;
    logic        AdEL;
    logic        AdES;

    always #5 clk = ~clk;

    dm_store #(.WORDS(4096)) dut (
        .clk  (clk),
        .reset(reset),
        .we   (we),
        .re   (re),
        .op   (op),
        .Addr (Addr),
        .Din  (Din),
        .PC   (PC),
        .Dout (Dout),
        .be   (be),
        .AdEL (AdEL),
        .AdES (AdES)
    );

`ifdef DM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] sb_q [$];
    logic [31:0] exp_d;
    logic [31:0] model [4096];

    function automatic logic [3:0] ref_be(input logic [2:0] o, input logic [31:0] a);
        case (o)
            3'b000:         return 4'b1111;
            3'b001, 3'b010: return 4'b0001 << a[1:0];
            3'b011, 3'b100: return a[1] ? 4'b1100 : 4'b0011;
            default:        return 4'b0000;
        endcase
    endfunction

    function automatic logic ref_mis(input logic [2:0] o, input logic [31:0] a);
        return ((o == 3'b000) && (a[1:0] != 2'b00)) ||
               (((o == 3'b011) || (o == 3'b100)) && a[0]);
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] d,
                                              input logic [2:0] o, input logic [3:0] b);
        logic [31:0] lane;
        logic [31:0] res;
        case (o)
            3'b000:         lane = d;
            3'b011, 3'b100: lane = {d[15:0], d[15:0]};
            default:        lane = {d[7:0], d[7:0], d[7:0], d[7:0]};
        endcase
        res = old;
        for (int k = 0; k < 4; k++) begin
            if (b[k]) res[8*k +: 8] = lane[8*k +: 8];
        end
        return res;
    endfunction

    task automatic drive(input logic w, input logic r, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
        we = w; re = r; op = o; Addr = a; Din = d; PC = p;
    endtask

    // Mirrors what the upcoming edge should do to memory, from the current inputs.
    task automatic commit_model();
        logic [3:0] b;
        b = ref_be(op, Addr);
        if (!reset) begin
            for (int k = 0; k < 4096; k++) model[k] = '0;
        end else if (we && (b != 4'b0000) && !(TRAP && ref_mis(op, Addr))) begin
            model[Addr[13:2]] = ref_store(model[Addr[13:2]], Din, op, b);
        end
    endtask

    task automatic tick();
        commit_model();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        tick();
        reset = 1'b1;
        drive(1'b0, 1'b0, 3'b000, 32'h0000_0000, 32'h0, 32'h0);
        sb_q.push_back(32'h0);
        @(negedge clk);
        exp_d = sb_q.pop_front(); n_vec++;
        if (Dout !== exp_d) begin n_err++; $display("FAIL reset_rd0 got %h want %h", Dout, exp_d); end
        n_vec++;
        if ({be, AdEL, AdES} !== 6'b0) begin n_err++; $display("FAIL reset_idle_flags got %b want 000000", {be, AdEL, AdES}); end
        tick();
        drive(1'b0, 1'b0, 3'b000, 32'h0000_3FFC, 32'h0, 32'h0);
        sb_q.push_back(32'h0);
        @(negedge clk);
        exp_d = sb_q.pop_front(); n_vec++;
        if (Dout !== exp_d) begin n_err++; $display("FAIL reset_rd3ffc got %h want %h", Dout, exp_d); end
        tick();
    endtask

    task automatic test_word();
        drive(1'b1, 1'b0, 3'b000, 32'h10, 32'h1234_5678, 32'h3000);
        sb_q.push_back(32'h0);
        @(negedge clk);
        exp_d = sb_q.pop_front(); n_vec++;
        if (Dout !== exp_d) begin n_err++; $display("FAIL sw_old got %h want %h", Dout, exp_d); end
        n_vec++;
        if (be !== 4'b1111) begin n_err++; $display("FAIL sw_be got %b want 1111", be); end
        tick();
        drive(1'b0, 1'b0, 3'b000, 32'h10, 32'h0, 32'h0);
        sb_q.push_back(32'h1234_5678);
        @(negedge clk);
        exp_d = sb_q.pop_front(); n_vec++;
        if (Dout !== exp_d) begin n_err++; $display("FAIL sw_new got %h want %h", Dout, exp_d); end
        tick();
    endtask

    task automatic test_merge();
        drive(1'b1, 1'b0, 3'b001, 32'h11, 32'h0000_00AB, 32'h3004);
        sb_q.push_back(32'h1234_5678);
        @(negedge clk);
        exp_d = sb_q.pop_front(); n_vec++;
        if (Dout !== exp_d) begin n_err++; $display("FAIL sb_old got %h want %h", Dout, exp_d); end
        n_vec++;
        if (be !== 4'b0010) begin n_err++; $display("FAIL sb_be got %b want 0010", be); end
        tick();
        drive(1'b1, 1'b0, 3'b011, 32'h12, 32'h0000_CDEF, 32'h3008);
        sb_q.push_back(32'h1234_AB78);
        @(negedge clk);
        exp_d = sb_q.pop_front(); n_vec++;
        if (Dout !== exp_d) begin n_err++; $display("FAIL sb_merge got %h want %h", Dout, exp_d); end
        n_vec++;
        if (be !== 4'b1100) begin n_err++; $display("FAIL sh_be got %b want 1100", be); end
        tick();
        drive(1'b0, 1'b0, 3'b000, 32'h10, 32'h0, 32'h0);
        sb_q.push_back(32'hCDEF_AB78);
        @(negedge clk);
        exp_d = sb_q.pop_front(); n_vec++;
        if (Dout !== exp_d) begin n_err++; $display("FAIL sh_merge got %h want %h", Dout, exp_d); end
        tick();
    endtask

    task automatic test_rdw();
        drive(1'b1, 1'b0, 3'b000, 32'h20, 32'hFFFF_FFFF, 32'h300C);
        sb_q.push_back(32'h0);
        @(negedge clk);
        exp_d = sb_q.pop_front(); n_vec++;
        if (Dout !== exp_d) begin n_err++; $display("FAIL rdw_during got %h want %h", Dout, exp_d); end
        tick();
        sb_q.push_back(32'hFFFF_FFFF);
        @(negedge clk);
        exp_d = sb_q.pop_front(); n_vec++;
        if (Dout !== exp_d) begin n_err++; $display("FAIL rdw_after got %h want %h", Dout, exp_d); end
        we = 1'b0;
        tick();
    endtask

    task automatic test_misalign();
        drive(1'b1, 1'b0, 3'b000, 32'h22, 32'h1111_1111, 32'h3010);
        @(negedge clk);
        n_vec++;
        if (AdES !== TRAP) begin n_err++; $display("FAIL mis_sw_ades got %b want %b", AdES, TRAP); end
        n_vec++;
        if (AdEL !== 1'b0) begin n_err++; $display("FAIL mis_sw_adel got %b want 0", AdEL); end
        tick();
        drive(1'b0, 1'b0, 3'b000, 32'h20, 32'h0, 32'h0);
        sb_q.push_back(TRAP ? 32'hFFFF_FFFF : 32'h1111_1111);
        @(negedge clk);
        exp_d = sb_q.pop_front(); n_vec++;
        if (Dout !== exp_d) begin n_err++; $display("FAIL mis_sw_mem got %h want %h", Dout, exp_d); end
        tick();
        drive(1'b0, 1'b1, 3'b011, 32'h21, 32'h0, 32'h0);
        @(negedge clk);
        n_vec++;
        if ({AdEL, AdES, be} !== {TRAP, 1'b0, 4'b0011}) begin
            n_err++; $display("FAIL mis_lh got %b want %b", {AdEL, AdES, be}, {TRAP, 1'b0, 4'b0011});
        end
        tick();
        drive(1'b1, 1'b0, 3'b011, 32'h21, 32'h0000_2222, 32'h3014);
        @(negedge clk);
        n_vec++;
        if ({AdES, be} !== {TRAP, 4'b0011}) begin
            n_err++; $display("FAIL mis_sh got %b want %b", {AdES, be}, {TRAP, 4'b0011});
        end
        tick();
        drive(1'b0, 1'b0, 3'b000, 32'h20, 32'h0, 32'h0);
        sb_q.push_back(TRAP ? 32'hFFFF_FFFF : 32'h1111_2222);
        @(negedge clk);
        exp_d = sb_q.pop_front(); n_vec++;
        if (Dout !== exp_d) begin n_err++; $display("FAIL mis_sh_mem got %h want %h", Dout, exp_d); end
        tick();
        drive(1'b1, 1'b1, 3'b000, 32'h23, 32'h3333_3333, 32'h3018);
        @(negedge clk);
        n_vec++;
        if ({AdEL, AdES} !== {TRAP, TRAP}) begin
            n_err++; $display("FAIL mis_both got %b want %b", {AdEL, AdES}, {TRAP, TRAP});
        end
        tick();
        drive(1'b0, 1'b0, 3'b000, 32'h20, 32'h0, 32'h0);
        sb_q.push_back(TRAP ? 32'hFFFF_FFFF : 32'h3333_3333);
        @(negedge clk);
        exp_d = sb_q.pop_front(); n_vec++;
        if (Dout !== exp_d) begin n_err++; $display("FAIL mis_both_mem got %h want %h", Dout, exp_d); end
        tick();
    endtask

    task automatic test_reset_collision();
        reset = 1'b0;
        drive(1'b1, 1'b0, 3'b000, 32'h40, 32'h0000_0055, 32'h301C);
        tick();
        reset = 1'b1;
        drive(1'b0, 1'b0, 3'b000, 32'h40, 32'h0, 32'h0);
        sb_q.push_back(32'h0);
        @(negedge clk);
        exp_d = sb_q.pop_front(); n_vec++;
        if (Dout !== exp_d) begin n_err++; $display("FAIL rst_coll_40 got %h want %h", Dout, exp_d); end
        tick();
        drive(1'b0, 1'b0, 3'b000, 32'h10, 32'h0, 32'h0);
        sb_q.push_back(32'h0);
        @(negedge clk);
        exp_d = sb_q.pop_front(); n_vec++;
        if (Dout !== exp_d) begin n_err++; $display("FAIL rst_coll_10 got %h want %h", Dout, exp_d); end
        tick();
    endtask

    task automatic test_illegal();
        drive(1'b1, 1'b0, 3'b111, 32'h40, 32'hDEAD_BEEF, 32'h3020);
        @(negedge clk);
        n_vec++;
        if ({be, AdEL, AdES} !== 6'b0) begin n_err++; $display("FAIL illegal_be got %b want 000000", {be, AdEL, AdES}); end
        tick();
        drive(1'b1, 1'b1, 3'b101, 32'h41, 32'hDEAD_BEEF, 32'h3024);
        sb_q.push_back(32'h0);
        @(negedge clk);
        exp_d = sb_q.pop_front(); n_vec++;
        if (Dout !== exp_d) begin n_err++; $display("FAIL illegal_mem got %h want %h", Dout, exp_d); end
        n_vec++;
        if ({be, AdEL, AdES} !== 6'b0) begin n_err++; $display("FAIL illegal_101 got %b want 000000", {be, AdEL, AdES}); end
        tick();
        drive(1'b0, 1'b0, 3'b000, 32'h40, 32'h0, 32'h0);
        sb_q.push_back(32'h0);
        @(negedge clk);
        exp_d = sb_q.pop_front(); n_vec++;
        if (Dout !== exp_d) begin n_err++; $display("FAIL illegal_mem2 got %h want %h", Dout, exp_d); end
        tick();
    endtask

    task automatic test_wrap();
        drive(1'b1, 1'b0, 3'b000, 32'h4000, 32'hA5A5_A5A5, 32'h3028);
        tick();
        drive(1'b0, 1'b0, 3'b000, 32'h0000_0000, 32'h0, 32'h0);
        sb_q.push_back(32'hA5A5_A5A5);
        @(negedge clk);
        exp_d = sb_q.pop_front(); n_vec++;
        if (Dout !== exp_d) begin n_err++; $display("FAIL wrap_w0 got %h want %h", Dout, exp_d); end
        tick();
        drive(1'b0, 1'b0, 3'b000, 32'hFFFF_C000, 32'h0, 32'h0);
        sb_q.push_back(32'hA5A5_A5A5);
        @(negedge clk);
        exp_d = sb_q.pop_front(); n_vec++;
        if (Dout !== exp_d) begin n_err++; $display("FAIL wrap_hi got %h want %h", Dout, exp_d); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [3:0]  xb;
        logic        xm;
        for (int n = 0; n < 300; n++) begin
            a = ($urandom() & 32'hFFFF_C000) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            reset = ($urandom_range(0, 59) != 0);
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7), a,
                  $urandom(), 32'h4000 + 32'(n * 4));
            xb = (we || re) ? ref_be(op, Addr) : 4'b0000;
            xm = ref_mis(op, Addr);
            sb_q.push_back(model[Addr[13:2]]);
            @(negedge clk);
            exp_d = sb_q.pop_front(); n_vec++;
            if (Dout !== exp_d) begin n_err++; $display("FAIL b2b_dout[%0d] got %h want %h", n, Dout, exp_d); end
            n_vec++;
            if ({be, AdEL, AdES} !== {xb, TRAP && re && xm, TRAP && we && xm}) begin
                n_err++;
                $display("FAIL b2b_ctl[%0d] got %b want %b", n, {be, AdEL, AdES},
                         {xb, TRAP && re && xm, TRAP && we && xm});
            end
            tick();
        end
        reset = 1'b1;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        #1;
        test_reset();
        test_word();
        test_merge();
        test_rdw();
        test_misalign();
        test_reset_collision();
        test_illegal();
        test_wrap();
        test_back_to_back();
        n_vec++;
        if (sb_q.size() != 0) begin n_err++; $display("FAIL sb_drain got %0d want 0", sb_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dm_store.md
# dm_store

Data memory for the five-stage MIPS pipeline, in the MEM stage directly upstream of the load-extension unit. Holds 4096 32-bit words, performs sw/sh/sb stores through a byte-enable mask, and presents the whole addressed word on `Dout`. The load-extension unit selects and extends the byte or halfword from that word. The block also flags misaligned accesses and logs every committed store for comparison against the reference simulator.

## Interface
- `WORDS`, 4096: memory depth in words; word index is `Addr[13:2]`, and upper address bits are ignored.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `we` input 1: store enable (MemWrite from the MEM pipeline register).
- `re` input 1: load enable; used only for misalignment detection.
- `op` input 3: access width. `000` word, `001`/`010` byte, `011`/`100` halfword. Same encoding as the load-extension unit. `101`–`111` are illegal.
- `Addr` input 32: byte address (ALU result).
- `Din` input 32: store data, unshifted rt value.
- `PC` input 32: PC of the instruction in MEM; used only for the store log.
- `Dout` output 32: full word at `Addr[13:2]`, combinational read.
- `be` output 4: byte-enable mask for the current access.
- `AdEL` output 1: misaligned load flag.
- `AdES` output 1: misaligned store flag.

## Operation
- Byte-enable generation:
  - word → `1111`.
  - half → `0011` when `Addr[1]`=0, `1100` when `Addr[1]`=1.
  - byte → one-hot `0001 << Addr[1:0]`.
  - illegal `op` → `0000`.
- Write lane data:
  - word: `Din`.
  - half: `{Din[15:0],Din[15:0]}`.
  - byte: `Din[7:0]` replicated ×4.
  - Only lanes with `be` set are written; other bytes of the word are preserved.
- Misalignment (combinational):
  - `mis` = (word && `Addr[1:0]`≠0) || (half && `Addr[0]`).
  - `AdES` = `we` && `mis`.
  - `AdEL` = `re` && `mis`.
- Store log: every committed store prints `@%h: *%h <= %h` with PC, word-aligned address, and the merged new word value.
- Illegal `op` with `we`=1: no write, no log, no flag.
- `we` and `re` both high: the store proceeds normally; `AdEL` and `AdES` are evaluated independently.

## Timing
- Read is asynchronous: `Dout` tracks `Addr` and memory contents with zero cycle latency.
- Write commits at a rising edge when `reset`=1, `we`=1, and the store is not suppressed.
- Read-during-write to the same word: `Dout` shows the old word in that cycle and the new word after the edge.
- Reset:
  - At a rising edge with `reset`=0, all `WORDS` entries clear to 0 in that single edge.
  - A concurrent `we` is ignored, and no log is printed.
  - `Dout` is 0 after the reset edge for any address.
- Reset asserted mid-sequence: a store presented at the same edge as reset is lost. Stores on earlier edges are also lost because the memory is cleared.
- `be`, `AdEL`, `AdES` are purely combinational; they have no reset value of their own and are 0 whenever `we`=`re`=0.
- Address wrap: `Addr` 0x4000 aliases to word 0.

## Configuration
- Macro: `DM_MISALIGN_TRAP_EN`.
- Defined:
  - A misaligned store (`AdES`=1) is suppressed: no memory change, no log.
  - `AdEL`/`AdES` drive the CP0 exception path.
- Undefined:
  - `AdEL` and `AdES` are tied to 0.
  - Misaligned stores commit using `be` as computed, i.e. low address bits are truncated. Example: sh at offset 1 writes lanes `0011`.

## Test plan
- Reset → word: hold `reset`=0 one edge, then release. Read `Addr` 0x0000 and 0x3FFC → `Dout`=0. Then sw 0x12345678 to 0x10, PC 0x3000 → next cycle `Dout`=0x12345678; log `@00003000: *00000010 <= 12345678`.
- Byte/half merge: after sw 0x12345678 at 0x10, do sb 0xAB at 0x11, then sh 0xCDEF at 0x12 → `Dout`=0x1234AB78, then 0xCDEFAB78. `be` is `0010`, then `1100`.
- Read-during-write: sw 0xFFFFFFFF to 0x20 with `Addr` held → `Dout`=0 during that cycle and 0xFFFFFFFF after the edge.
- Misaligned trap, macro defined: sw 0x11111111 at 0x22 → `AdES`=1, word 0x20 unchanged, no log. lh with `re`=1 at 0x21 → `AdEL`=1. Macro undefined → both flags 0 and the sw writes all four lanes of word 0x20.
- Reset collision: `reset`=0 with sw 0x55 to 0x40 at the same edge → word 0x40 reads 0 and no log is printed.
- Illegal `op` 3'b111 with `we`=1 at 0x40 → `be`=0000, memory unchanged, no log.
